// File: rtl/dispatch_cluster.sv
// ============================================================================
//  Module      : dispatch_cluster
//  Description : DP-deep micro-op FIFO that dispatches its head entry atomically
//                to one of NCH issue channels and the in-order commit queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_cluster #(
    parameter int DW  = 128,
    parameter int OW  = 72,
    parameter int NCH = 8,
    parameter int DP  = 8
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  flush,
    input  logic                  rn_vaild,
    output logic                  rn_ready,
    input  logic [NCH-1:0]        rn_chn,
    input  logic [DW-1:0]         rn_info,
    input  logic [OW-1:0]         rn_order,
    output logic                  iOrder_vaild,
    input  logic                  iOrder_ready,
    output logic [OW-1:0]         iOrder_info,
    output logic [NCH-1:0]        issue_vaild,
    input  logic [NCH-1:0]        issue_ready,
    output logic [DW-1:0]         issue_info,
    output logic [$clog2(DP):0]   dispat_cnt
);

    localparam int AW = $clog2(DP);

    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [NCH-1:0]  r_mem_chn   [DP];
    logic [DW-1:0]   r_mem_info  [DP];
    logic [OW-1:0]   r_mem_order [DP];

    logic            w_full;
    logic            w_head_valid;
    logic [NCH-1:0]  w_head_chn;
    logic [NCH-1:0]  w_chn_norm;
    logic            w_target_ok;
    logic            w_push;
    logic            w_fire;

    // Full when indices match but the wrap bits differ.
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head_valid = (r_wr_ptr != r_rd_ptr);
    assign rn_ready     = ~w_full;
    assign dispat_cnt   = r_wr_ptr - r_rd_ptr;

    // Two's-complement trick isolates the lowest set bit of a multi-hot target.
    assign w_chn_norm   = rn_chn & (~rn_chn + NCH'(1));

    assign w_head_chn   = w_head_valid ? r_mem_chn[r_rd_ptr[AW-1:0]]   : '0;
    assign issue_info   = w_head_valid ? r_mem_info[r_rd_ptr[AW-1:0]]  : '0;
    assign iOrder_info  = w_head_valid ? r_mem_order[r_rd_ptr[AW-1:0]] : '0;

    // A no-issue op (all-zero target) only needs the commit queue.
    assign w_target_ok  = (w_head_chn == '0) || ((w_head_chn & issue_ready) != '0);
    assign iOrder_vaild = w_head_valid & w_target_ok;
    assign issue_vaild  = w_head_chn & {NCH{w_head_valid & iOrder_ready}};

    assign w_fire       = w_head_valid & iOrder_ready & w_target_ok;
    assign w_push       = rn_vaild & ~w_full;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only visible once the pointers cover it.
    always_ff @(posedge CLK) begin
        if (w_push && !flush) begin
            r_mem_chn[r_wr_ptr[AW-1:0]]   <= w_chn_norm;
            r_mem_info[r_wr_ptr[AW-1:0]]  <= rn_info;
            r_mem_order[r_wr_ptr[AW-1:0]] <= rn_order;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_cluster.sv
// ============================================================================
//  Module      : tb_dispatch_cluster
//  Description : Scoreboard bench for dispatch_cluster with a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dispatch_cluster;

    localparam int DW  = 128;
    localparam int OW  = 72;
    localparam int NCH = 8;
    localparam int DP  = 8;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic            flush;
    logic            rn_vaild;
    logic            rn_ready;
    logic [NCH-1:0]  rn_chn;
    logic [DW-1:0]   rn_info;
    logic [OW-1:0]   rn_order;
    logic            iOrder_vaild;
    logic            iOrder_ready;
    logic [OW-1:0]   iOrder_info;
    logic [NCH-1:0]  issue_vaild;
    logic [NCH-1:0]  issue_ready;
    logic [DW-1:0]   issue_info;
    logic [3:0]      dispat_cnt;

    dispatch_cluster #(.DW(DW), .OW(OW), .NCH(NCH), .DP(DP)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .flush        (flush),
        .rn_vaild     (rn_vaild),
        .rn_ready     (rn_ready),
        .rn_chn       (rn_chn),
        .rn_info      (rn_info),
        .rn_order     (rn_order),
        .iOrder_vaild (iOrder_vaild),
        .iOrder_ready (iOrder_ready),
        .iOrder_info  (iOrder_info),
        .issue_vaild  (issue_vaild),
        .issue_ready  (issue_ready),
        .issue_info   (issue_info),
        .dispat_cnt   (dispat_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NCH-1:0] chn;
        logic [DW-1:0]  info;
        logic [OW-1:0]  order;
    } op_t;

    op_t model_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  n_fired = 0;
    bit  random_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] lowest_bit(input logic [NCH-1:0] c);
        for (int i = 0; i < NCH; i++) begin
            if (c[i]) return NCH'(1) << i;
        end
        return '0;
    endfunction

    // Monitor: compare the DUT against the model head, then advance the model.
    always @(negedge CLK) begin
        if (!RSTn) begin
            model_q.delete();
        end else begin
            int             sz;
            logic           tgt_ok;
            logic           exp_ov;
            logic           exp_fire;
            logic [NCH-1:0] exp_iv;
            logic [DW-1:0]  exp_info;
            logic [OW-1:0]  exp_order;
            sz        = model_q.size();
            exp_ov    = 1'b0;
            exp_fire  = 1'b0;
            exp_iv    = '0;
            exp_info  = '0;
            exp_order = '0;
            if (sz > 0) begin
                tgt_ok    = (model_q[0].chn == '0) || ((model_q[0].chn & issue_ready) != '0);
                exp_ov    = tgt_ok;
                exp_iv    = iOrder_ready ? model_q[0].chn : '0;
                exp_fire  = iOrder_ready && tgt_ok;
                exp_info  = model_q[0].info;
                exp_order = model_q[0].order;
            end
            chk("dispat_cnt",   128'(dispat_cnt),   128'(sz));
            chk("rn_ready",     128'(rn_ready),     128'(sz < DP));
            chk("iOrder_vaild", 128'(iOrder_vaild), 128'(exp_ov));
            chk("issue_vaild",  128'(issue_vaild),  128'(exp_iv));
            chk("issue_info",   issue_info,         exp_info);
            chk("iOrder_info",  128'(iOrder_info),  128'(exp_order));
            if (flush) begin
                model_q.delete();
            end else begin
                if (exp_fire) begin
                    void'(model_q.pop_front());
                    n_fired++;
                end
                if (rn_vaild && sz < DP) begin
                    op_t e;
                    e.chn   = lowest_bit(rn_chn);
                    e.info  = rn_info;
                    e.order = rn_order;
                    model_q.push_back(e);
                end
            end
        end
    end

    task automatic push_op(input logic [NCH-1:0] c, input logic [DW-1:0] inf, input logic [OW-1:0] ord);
        bit ok;
        ok       = 0;
        rn_vaild = 1'b1;
        rn_chn   = c;
        rn_info  = inf;
        rn_order = ord;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge CLK);
            ok = rn_ready && !flush;
            @(posedge CLK);
            #1;
        end
        rn_vaild = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: got not-accepted expected accepted (t=%0t)", $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_info();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [OW-1:0] rnd_order();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    function automatic logic [NCH-1:0] rnd_chn();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel <= 2) return NCH'($urandom);
        return NCH'(1) << $urandom_range(0, NCH - 1);
    endfunction

    initial begin
        int fired_before;
        bit drained;
        RSTn = 1'b0; flush = 1'b0; rn_vaild = 1'b0; rn_chn = '0;
        rn_info = '0; rn_order = '0; iOrder_ready = 1'b0; issue_ready = '0;
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;

        // Reset/empty: monitor checks idle outputs.
        repeat (3) @(posedge CLK);
        #1;

        // Single op.
        iOrder_ready = 1'b1; issue_ready = '1;
        push_op(8'h04, 128'hA5, 72'h1);
        repeat (3) @(posedge CLK);
        #1;

        // Stall on channel 2, then release.
        issue_ready = 8'hFB;
        fired_before = n_fired;
        push_op(8'h04, 128'h5A5A, 72'h2);
        repeat (5) @(posedge CLK);
        #1 issue_ready = '1;
        repeat (3) @(posedge CLK);
        #1;
        chk("stall_fire_once", 128'(n_fired - fired_before), 128'(1));

        // Fill to full with nothing ready, then back-to-back push+fire.
        iOrder_ready = 1'b0; issue_ready = '0;
        for (int i = 0; i < DP; i++) push_op(rnd_chn(), rnd_info(), rnd_order());
        repeat (2) @(posedge CLK);
        #1 iOrder_ready = 1'b1; issue_ready = '1;
        for (int i = 0; i < 16; i++) push_op(8'h01 << (i % 8), rnd_info(), 72'(i));
        repeat (DP + 2) @(posedge CLK);
        #1;

        // No-issue op and multi-hot normalisation.
        iOrder_ready = 1'b1; issue_ready = '0;
        push_op(8'h00, 128'hDEAD, 72'h3);
        repeat (2) @(posedge CLK);
        #1 issue_ready = '1;
        push_op(8'h0C, 128'hBEEF, 72'h4);
        repeat (3) @(posedge CLK);
        #1;

        // Flush with a same-cycle push.
        iOrder_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(rnd_chn(), rnd_info(), rnd_order());
        flush = 1'b1; rn_vaild = 1'b1; rn_chn = 8'h02; rn_info = 128'h77;
        @(posedge CLK);
        #1 flush = 1'b0; rn_vaild = 1'b0;
        @(negedge CLK);
        chk("flush_cnt", 128'(dispat_cnt), 128'(0));
        @(posedge CLK);
        #1;

        // Asynchronous reset mid-stall.
        for (int i = 0; i < 3; i++) push_op(8'h10, rnd_info(), rnd_order());
        #2 RSTn = 1'b0;
        #1;
        chk("rst_cnt",    128'(dispat_cnt),   128'(0));
        chk("rst_ready",  128'(rn_ready),     128'(1));
        chk("rst_ov",     128'(iOrder_vaild), 128'(0));
        chk("rst_iv",     128'(issue_vaild),  128'(0));
        chk("rst_info",   issue_info,         128'(0));
        @(posedge CLK);
        #2 RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Randomised traffic with random readiness and occasional flushes.
        fork
            begin
                for (int i = 0; i < 300; i++) push_op(rnd_chn(), rnd_info(), rnd_order());
                random_done = 1;
            end
            begin
                while (!random_done) begin
                    @(posedge CLK);
                    #1;
                    iOrder_ready = ($urandom_range(0, 3) != 0);
                    issue_ready  = NCH'($urandom) | NCH'($urandom);
                    flush        = ($urandom_range(0, 40) == 0);
                end
            end
        join
        flush = 1'b0; iOrder_ready = 1'b1; issue_ready = '1;

        drained = 0;
        for (int k = 0; k < 100 && !drained; k++) begin
            @(negedge CLK);
            drained = (dispat_cnt == 0);
        end
        chk("drain", 128'(drained), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
